roce_tx_write_sequencer: RTL
============================

# roce_tx_write_sequencer

Drives the RoCE stack's transmit interface from the user kernel. On a start pulse, it issues a configured burst of RDMA WRITE requests on the tx meta stream and streams a generated payload for each request on the tx data stream. It retires completions from the tx status stream, bounded by an outstanding-request limit, and reports done plus error counts to the kernel control logic.

## Interface
- MAX_OUTSTANDING, 4: maximum issued requests without a status completion (1..15).
- META_W, 256: tx meta tdata width.
- DATA_W, 512: tx data tdata width (64 bytes/beat).
- STATUS_W, 512: tx status tdata width.

Ports:
- ap_clk  in  1  sole clock.
- areset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; ignored unless idle.
- cfg_qpn  in  24  queue pair number.
- cfg_num_reqs  in  16  number of WRITE requests.
- cfg_len  in  32  bytes per request.
- cfg_laddr  in  64  local base virtual address.
- cfg_raddr  in  64  remote base virtual address.
- m_axis_tx_meta_tvalid/tready/tdata[META_W]/tkeep[META_W/8]/tlast  out/in/out/out/out  request descriptor.
- m_axis_tx_data_tvalid/tready/tdata[DATA_W]/tkeep[DATA_W/8]/tlast  out/in/out/out/out  payload.
- s_axis_tx_status_tvalid/tready/tdata[STATUS_W]/tkeep/tlast  in/out/in/in/in  completion.
- busy  out  1  high from start acceptance to done.
- done  out  1  one-cycle pulse at burst end.
- cmp_cnt  out  16  completions received this burst.
- err_cnt  out  16  completions with error bit set this burst.

## Operation
- All cfg_* fields are latched on an accepted start.
- cmp_cnt and err_cnt clear on an accepted start. They hold their values after done.
- Meta tdata layout:
  - [7:0] opcode = 8'h01 (WRITE).
  - [31:8] qpn.
  - [95:32] laddr_i = cfg_laddr + i*cfg_len.
  - [159:96] raddr_i = cfg_raddr + i*cfg_len.
  - [191:160] cfg_len.
  - Remaining bits 0.
  - tkeep is all ones; tlast = 1.
- Address arithmetic is 64-bit modulo 2^64 (wrap is silent).
- Beats per request = ceil(cfg_len/64).
- Payload word w (32-bit, w=0..15) of beat b of request i = {i[15:0], b[15:0]}.
- Last beat: tlast = 1. tkeep = low (cfg_len mod 64) bytes set, or all ones if the remainder is 0. All other beats have tkeep all ones.
- States:
  - IDLE: start accepted -> if cfg_num_reqs == 0 or cfg_len == 0, go to DONE; else go to META.
  - META: meta tvalid = 1 only while outstanding < MAX_OUTSTANDING. On handshake: outstanding++, go to DATA.
  - DATA: stream beats. On last-beat handshake: if issued == num_reqs go to WAIT_CMP, else go to META.
  - WAIT_CMP: go to DONE when cmp_cnt == num_reqs.
  - DONE: done = 1 for one cycle, then IDLE.
- Status tready = 1 in every state. A status handshake in any non-IDLE state increments cmp_cnt, decrements outstanding, and increments err_cnt if tdata[0] == 1.
- A status beat accepted in IDLE is discarded and changes no counter.
- Simultaneous meta handshake and status handshake: outstanding unchanged; cmp_cnt still increments.
- cmp_cnt and err_cnt saturate at 16'hFFFF.
- outstanding never underflows: a status received with outstanding == 0 increments cmp_cnt only.
- tvalid, once asserted on either master stream, holds with tdata stable until tready (AXI4-Stream rules).
- start while busy is ignored and has no effect on latched configuration.

## Timing
- Reset values: all tvalid = 0, tdata/tkeep/tlast = 0, s_axis_tx_status_tready = 1, busy = 0, done = 0, counters = 0, state IDLE.
- Reset mid-burst aborts immediately (asynchronously); nothing is resumed.
- start at cycle t -> busy = 1 at t+1, meta tvalid = 1 at t+1.
- Meta handshake at cycle t -> first data tvalid at t+1.
- Last-beat handshake at cycle t -> next meta tvalid at t+1, if the outstanding limit allows.
- Data beats stream back-to-back under continuous tready: 1 beat/cycle.
- Final completion accepted at cycle t -> done = 1 and busy = 0 at t+1, state IDLE at t+2.
- Zero-length burst: start at t -> done at t+1, no stream traffic.

## Test plan
- Basic burst: num_reqs=2, len=128, laddr=0x1000, raddr=0x8000, tready=1, two status beats with tdata[0]=0.
  - Expect meta with raddr 0x8000 then 0x8080.
  - Expect 2 beats/request with tlast on beat 1; word 0 of request 1 beat 1 = 0x00010001.
  - Expect done; cmp_cnt=2, err_cnt=0.
- Partial tail: len=100.
  - Expect 2 beats; last tkeep = 0x0000_000F_FFFF_FFFF (36 bytes).
- Backpressure: random data/meta tready at 50%.
  - tdata/tkeep/tlast stable while tvalid && !tready; beat sequence unchanged.
- Outstanding limit: MAX_OUTSTANDING=4, num_reqs=8, status withheld.
  - Exactly 4 meta handshakes, then meta tvalid stays 0.
  - Release one status -> the 5th meta issues.
- Errors and edges:
  - 3 requests, status tdata[0] = 1 on the second -> err_cnt=1.
  - num_reqs=0 -> done 1 cycle after start with no traffic.
  - start pulsed while busy is ignored.
  - Status injected in IDLE leaves counters at 0.
- Reset mid-DATA: assert areset during beat 1.
  - All tvalid drop asynchronously; busy = 0.
  - A fresh start after reset runs a full burst correctly.

Source files
------------

// File: rtl/roce_tx_write_sequencer_if.sv
// Stream bundle between the RDMA WRITE sequencer and the RoCE transmit path:
// request descriptors (meta), payload (data) and completions (status).
interface roce_tx_write_sequencer_if #(
  parameter int unsigned META_W   = 256,
  parameter int unsigned DATA_W   = 512,
  parameter int unsigned STATUS_W = 512
);

  logic                    m_axis_tx_meta_tvalid;
  logic                    m_axis_tx_meta_tready;
  logic [META_W-1:0]       m_axis_tx_meta_tdata;
  logic [META_W/8-1:0]     m_axis_tx_meta_tkeep;
  logic                    m_axis_tx_meta_tlast;

  logic                    m_axis_tx_data_tvalid;
  logic                    m_axis_tx_data_tready;
  logic [DATA_W-1:0]       m_axis_tx_data_tdata;
  logic [DATA_W/8-1:0]     m_axis_tx_data_tkeep;
  logic                    m_axis_tx_data_tlast;

  logic                    s_axis_tx_status_tvalid;
  logic                    s_axis_tx_status_tready;
  logic [STATUS_W-1:0]     s_axis_tx_status_tdata;
  logic [STATUS_W/8-1:0]   s_axis_tx_status_tkeep;
  logic                    s_axis_tx_status_tlast;

  // Sequencer side: sources meta and data, sinks status.
  modport master (
    output m_axis_tx_meta_tvalid, m_axis_tx_meta_tdata, m_axis_tx_meta_tkeep,
           m_axis_tx_meta_tlast,
    input  m_axis_tx_meta_tready,
    output m_axis_tx_data_tvalid, m_axis_tx_data_tdata, m_axis_tx_data_tkeep,
           m_axis_tx_data_tlast,
    input  m_axis_tx_data_tready,
    input  s_axis_tx_status_tvalid, s_axis_tx_status_tdata, s_axis_tx_status_tkeep,
           s_axis_tx_status_tlast,
    output s_axis_tx_status_tready
  );

  // RoCE stack side.
  modport slave (
    input  m_axis_tx_meta_tvalid, m_axis_tx_meta_tdata, m_axis_tx_meta_tkeep,
           m_axis_tx_meta_tlast,
    output m_axis_tx_meta_tready,
    input  m_axis_tx_data_tvalid, m_axis_tx_data_tdata, m_axis_tx_data_tkeep,
           m_axis_tx_data_tlast,
    output m_axis_tx_data_tready,
    output s_axis_tx_status_tvalid, s_axis_tx_status_tdata, s_axis_tx_status_tkeep,
           s_axis_tx_status_tlast,
    input  s_axis_tx_status_tready
  );

endinterface

// File: rtl/roce_tx_write_sequencer.sv
// Issues a burst of RDMA WRITE requests (descriptor + generated payload) on the
// RoCE transmit streams, retires completions under an outstanding-request limit
// and reports done plus completion/error counts.
module roce_tx_write_sequencer #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned META_W          = 256,
  parameter int unsigned DATA_W          = 512,
  parameter int unsigned STATUS_W        = 512
) (
  input  logic        ap_clk,
  input  logic        areset,
  input  logic        start,
  input  logic [23:0] cfg_qpn,
  input  logic [15:0] cfg_num_reqs,
  input  logic [31:0] cfg_len,
  input  logic [63:0] cfg_laddr,
  input  logic [63:0] cfg_raddr,
  roce_tx_write_sequencer_if.master tx,
  output logic        busy,
  output logic        done,
  output logic [15:0] cmp_cnt,
  output logic [15:0] err_cnt
);

  localparam int unsigned BEAT_BYTES = DATA_W / 8;
  localparam int unsigned OFF_W      = $clog2(BEAT_BYTES);
  // Beat index within a request; the payload uses its low 16 bits.
  localparam int unsigned BEAT_W     = 32 - OFF_W;
  localparam int unsigned WORDS      = DATA_W / 32;
  localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MaxOut = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {StIdle, StMeta, StData, StWaitCmp, StDone} state_e;

  state_e                 state_q;
  logic [23:0]            qpn_q;
  logic [15:0]            num_q;
  logic [31:0]            len_q;
  logic [63:0]            laddr_q;
  logic [63:0]            raddr_q;
  logic [15:0]            req_q;
  logic [BEAT_W-1:0]      beat_q;
  logic [BEAT_W-1:0]      last_beat_q;
  logic [BEAT_BYTES-1:0]  tail_keep_q;
  logic [OUT_W-1:0]       out_q;

  logic                   meta_valid_q;
  logic [META_W-1:0]      meta_data_q;
  logic [META_W/8-1:0]    meta_keep_q;
  logic                   meta_last_q;
  logic                   data_valid_q;
  logic [DATA_W-1:0]      data_data_q;
  logic [BEAT_BYTES-1:0]  data_keep_q;
  logic                   data_last_q;

  logic                   meta_hs;
  logic                   data_hs;
  logic                   status_hs;
  logic [OUT_W-1:0]       out_d;
  logic [15:0]            cmp_d;
  logic [15:0]            err_d;
  logic [BEAT_W-1:0]      beat_nxt;
  logic [31:0]            len_m1;
  logic [OFF_W-1:0]       len_rem;
  logic [BEAT_BYTES-1:0]  cfg_tail_keep;
  logic                   unused_status;

  // Descriptor layout: opcode, qpn, local address, remote address, length.
  function automatic logic [META_W-1:0] meta_word(input logic [23:0] qpn,
                                                  input logic [63:0] la,
                                                  input logic [63:0] ra,
                                                  input logic [31:0] len);
    logic [META_W-1:0] m;
    m          = '0;
    m[7:0]     = 8'h01;
    m[31:8]    = qpn;
    m[95:32]   = la;
    m[159:96]  = ra;
    m[191:160] = len;
    return m;
  endfunction

  assign tx.m_axis_tx_meta_tvalid   = meta_valid_q;
  assign tx.m_axis_tx_meta_tdata    = meta_data_q;
  assign tx.m_axis_tx_meta_tkeep    = meta_keep_q;
  assign tx.m_axis_tx_meta_tlast    = meta_last_q;
  assign tx.m_axis_tx_data_tvalid   = data_valid_q;
  assign tx.m_axis_tx_data_tdata    = data_data_q;
  assign tx.m_axis_tx_data_tkeep    = data_keep_q;
  assign tx.m_axis_tx_data_tlast    = data_last_q;
  // Completions are always accepted; those arriving while idle are dropped.
  assign tx.s_axis_tx_status_tready = 1'b1;

  assign unused_status = ^{tx.s_axis_tx_status_tdata[STATUS_W-1:1],
                           tx.s_axis_tx_status_tkeep, tx.s_axis_tx_status_tlast};

  assign meta_hs   = meta_valid_q & tx.m_axis_tx_meta_tready;
  assign data_hs   = data_valid_q & tx.m_axis_tx_data_tready;
  assign status_hs = tx.s_axis_tx_status_tvalid & (state_q != StIdle);
  assign beat_nxt  = beat_q + BEAT_W'(1);
  assign len_m1    = cfg_len - 32'd1;
  assign len_rem   = cfg_len[OFF_W-1:0];
  assign cfg_tail_keep = (len_rem == '0) ? '1 : ~({BEAT_BYTES{1'b1}} << len_rem);

  // Outstanding and completion counters: next values from this cycle's handshakes.
  always_comb begin
    out_d = out_q;
    if (meta_hs && !status_hs) begin
      out_d = out_q + OUT_W'(1);
    end else if (status_hs && !meta_hs && out_q != '0) begin
      out_d = out_q - OUT_W'(1);
    end
    cmp_d = cmp_cnt;
    err_d = err_cnt;
    if (status_hs && cmp_cnt != 16'hFFFF) begin
      cmp_d = cmp_cnt + 16'd1;
    end
    if (status_hs && tx.s_axis_tx_status_tdata[0] && err_cnt != 16'hFFFF) begin
      err_d = err_cnt + 16'd1;
    end
  end

  // Sequencer FSM with registered stream outputs and status.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q      <= StIdle;
      qpn_q        <= '0;
      num_q        <= '0;
      len_q        <= '0;
      laddr_q      <= '0;
      raddr_q      <= '0;
      req_q        <= '0;
      beat_q       <= '0;
      last_beat_q  <= '0;
      tail_keep_q  <= '0;
      out_q        <= '0;
      meta_valid_q <= 1'b0;
      meta_data_q  <= '0;
      meta_keep_q  <= '0;
      meta_last_q  <= 1'b0;
      data_valid_q <= 1'b0;
      data_data_q  <= '0;
      data_keep_q  <= '0;
      data_last_q  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cmp_cnt      <= '0;
      err_cnt      <= '0;
    end else begin
      done    <= 1'b0;
      out_q   <= out_d;
      cmp_cnt <= cmp_d;
      err_cnt <= err_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            qpn_q       <= cfg_qpn;
            num_q       <= cfg_num_reqs;
            len_q       <= cfg_len;
            laddr_q     <= cfg_laddr;
            raddr_q     <= cfg_raddr;
            req_q       <= '0;
            last_beat_q <= len_m1[31:OFF_W];
            tail_keep_q <= cfg_tail_keep;
            out_q       <= '0;
            cmp_cnt     <= '0;
            err_cnt     <= '0;
            if (cfg_num_reqs == 16'd0 || cfg_len == 32'd0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q      <= StMeta;
              busy         <= 1'b1;
              meta_valid_q <= 1'b1;
              meta_data_q  <= meta_word(cfg_qpn, cfg_laddr, cfg_raddr, cfg_len);
              meta_keep_q  <= '1;
              meta_last_q  <= 1'b1;
            end
          end
        end
        StMeta: begin
          if (meta_hs) begin
            meta_valid_q <= 1'b0;
            state_q      <= StData;
            beat_q       <= '0;
            data_valid_q <= 1'b1;
            data_data_q  <= {WORDS{req_q, 16'h0000}};
            data_keep_q  <= (last_beat_q == '0) ? tail_keep_q : '1;
            data_last_q  <= (last_beat_q == '0);
          end else if (!meta_valid_q && out_d < MaxOut) begin
            // Descriptor was preloaded; only the valid waits for credit.
            meta_valid_q <= 1'b1;
          end
        end
        StData: begin
          if (data_hs) begin
            if (data_last_q) begin
              data_valid_q <= 1'b0;
              if (req_q == num_q - 16'd1) begin
                state_q <= StWaitCmp;
              end else begin
                state_q      <= StMeta;
                req_q        <= req_q + 16'd1;
                laddr_q      <= laddr_q + 64'(len_q);
                raddr_q      <= raddr_q + 64'(len_q);
                meta_data_q  <= meta_word(qpn_q, laddr_q + 64'(len_q), raddr_q + 64'(len_q),
                                          len_q);
                meta_valid_q <= (out_d < MaxOut);
              end
            end else begin
              beat_q      <= beat_nxt;
              data_data_q <= {WORDS{req_q, beat_nxt[15:0]}};
              data_keep_q <= (beat_nxt == last_beat_q) ? tail_keep_q : '1;
              data_last_q <= (beat_nxt == last_beat_q);
            end
          end
        end
        StWaitCmp: begin
          // >= rather than == so a stray early completion cannot stall the burst.
          if (cmp_d >= num_q) begin
            state_q <= StDone;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
